mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage RISC-V pipeline. It keeps at most one transaction outstanding and gives data accesses fixed priority, with an optional starvation guard for fetch. It routes each memory response back to its owner. The pipeline derives PC/IF-ID stalls from `if_req & !if_gnt` and EX-MEM/MEM-WB stalls from the data side.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, maximum number of consecutive data grants allowed while fetch waits (used only with the guard compiled in)

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch request; held stable with `if_addr` until granted
- `if_addr` in ADDR_W: fetch byte address
- `if_gnt` out 1: fetch request accepted this cycle
- `if_rvalid` out 1: fetch response valid
- `if_rdata` out DATA_W: fetch read data
- `dm_req` in 1: data request; held stable with its payload until granted
- `dm_we` in 1: 1 = write, 0 = read
- `dm_be` in DATA_W/8: byte enables for writes
- `dm_addr` in ADDR_W: data byte address
- `dm_wdata` in DATA_W: write data
- `dm_gnt` out 1: data request accepted this cycle
- `dm_rvalid` out 1: data response (read data or write acknowledge)
- `dm_rdata` out DATA_W: data read data
- `mem_req` out 1: request to memory; memory accepts it in the same cycle
- `mem_we` out 1: write enable to memory
- `mem_be` out DATA_W/8: byte enables to memory
- `mem_addr` out ADDR_W: address to memory
- `mem_wdata` out DATA_W: write data to memory
- `mem_rvalid` in 1: memory response valid; latency 1 or more cycles; exactly one per request, writes included
- `mem_rdata` in DATA_W: memory read data
- `busy` out 1: a transaction is outstanding

## Operation
- State machine `IDLE`, `WAIT_IF`, `WAIT_DM`. Reset value is `IDLE`.
- `free = (state==IDLE) | (state!=IDLE & mem_rvalid)`. Grants are issued only when `free` is 1.
- Selection when `free`:
  - `dm_req` wins over `if_req`.
  - With the guard compiled in, fetch wins when `starve_cnt==STARVE_MAX` and `if_req` is 1.
- A granted source drives `mem_*` combinationally in the same cycle (`mem_req=1`). The next state is `WAIT_DM` or `WAIT_IF`.
- If nothing is granted in a `free` cycle, `mem_req` is 0 and the next state is `IDLE`.
- Response routing:
  - `if_rvalid = mem_rvalid & state==WAIT_IF`
  - `dm_rvalid = mem_rvalid & state==WAIT_DM`
  - `if_rdata` and `dm_rdata` both pass `mem_rdata` through.
- `mem_rvalid` while in `IDLE` is spurious. It is dropped and not routed.
- When `mem_we=0`, `mem_be` and `mem_wdata` are driven to 0.
- `busy = (state!=IDLE)`.
- Simultaneous events: a response and a new grant in the same cycle are legal and are the back-to-back case.
- Reset mid-transaction forces `IDLE`. A late response after reset is dropped as spurious.
- Output values in reset and in `IDLE` with no requests: every output is 0.

## Timing
- Grant is combinational from `req`, `state` and `mem_rvalid`; there are no registered grants.
- A request granted in cycle T produces its owner's `rvalid` in cycle T+L, where L is the memory latency.
- With L=1, throughput is one transaction per cycle.
- Combinational paths `mem_rvalid` to `mem_req` and `mem_rvalid` to `*_gnt` are required; the memory must not combinationally depend on `mem_req` to produce `mem_rvalid`.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A `$clog2(STARVE_MAX+1)`-bit counter `starve_cnt` increments on each data grant while `if_req` is 1 and saturates at `STARVE_MAX`.
  - It clears to 0 on a fetch grant or whenever `if_req` is 0. Its reset value is 0.
- Macro undefined: no counter exists, and data has strict priority (fetch may starve indefinitely).

## Structure
- Package `common`: `arb_state_t` enum (`IDLE`, `WAIT_IF`, `WAIT_DM`) and `arb_owner_t` enum (`OWN_IF`, `OWN_DM`).
- `STARVE_MAX` stays a module parameter and is not placed in the package.
- One sub-module, `arb_starve_cnt`, holds the guard counter and its `force_if` output. It is instantiated only under `ARB_STARVE_GUARD_EN`.

## Test plan
- Reset / idle: assert `reset_n=0` for 3 cycles with `if_req=1`, then release with no requests → all outputs 0 during reset and after release, `busy=0`.
- Fetch only, L=1: `if_req=1`, `if_addr=0x0, 0x4, 0x8` → `if_gnt=1` every cycle; `if_rvalid` one cycle after each grant with matching `mem_rdata`; `mem_req` continuous.
- Contention: `if_req` and `dm_req` (read 0x100) rise together with the macro undefined → `dm_gnt=1`, `if_gnt=0`; `dm_rvalid` next cycle; `if_gnt` follows in the response cycle.
- Starvation guard: macro defined, `STARVE_MAX=4`, `dm_req` and `if_req` held high → grant sequence is DM, DM, DM, DM, IF, DM…; macro undefined → DM only.
- Write with L=3: `dm_we=1`, `dm_be=4'b0011`, addr 0x200, wdata 0xDEADBEEF → `mem_be=0011` in the grant cycle; `busy=1` for 3 cycles; `dm_rvalid` in T+3; `if_gnt=0` until T+3.
- Reset in `WAIT_DM`, with `mem_rvalid` pulsed 1 cycle after reset release → `if_rvalid=dm_rvalid=0`, state `IDLE`, and the next `if_req` is granted immediately.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Arbiter state and response-owner encodings.
package common;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the port arbiter.
// Latency: n/a (wires only). Backpressure: req held until gnt on each requester side.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [DATA_W/8-1:0]   dm_be;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Fetch starvation guard: counts consecutive data grants while fetch waits.
// Latency: force_if is registered, valid the cycle after the STARVE_MAX-th data grant.
// Backpressure: none; clears on fetch grant or whenever fetch is not requesting.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic dm_gnt,
    output logic force_if
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (if_gnt || !if_req) begin
            cnt_q <= '0;
        end else if (dm_gnt && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign force_if = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and MEM data requests onto one single-ported memory; ARB_STARVE_GUARD_EN adds a fetch starvation guard.
// Latency: grant and mem_* are combinational; owner rvalid arrives L cycles after grant, back-to-back at L=1.
// Backpressure: one transaction outstanding; a waiting requester holds req until its gnt.
module mem_port_arbiter
    import common::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);

    if (STARVE_MAX < 1) begin : g_starve_max_chk
        $error("STARVE_MAX must be at least 1");
    end

    arb_state_t          state_q;
    arb_state_t          state_d;
    arb_owner_t          owner;
    logic                free;
    logic                force_if;
    logic                gnt_if;
    logic                gnt_dm;

    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic [DATA_W/8-1:0] sel_be;
    logic [DATA_W-1:0]   sel_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Port is free when idle or when the outstanding response lands this cycle;
    // reset_n gates it so nothing is granted while reset is held.
    assign free = reset_n && ((state_q == IDLE) || bus.mem_rvalid);

    always_comb begin
        gnt_dm  = 1'b0;
        gnt_if  = 1'b0;
        state_d = state_q;
        if (free) begin
            if (bus.dm_req && !(force_if && bus.if_req)) begin
                gnt_dm = 1'b1;
            end else if (bus.if_req) begin
                gnt_if = 1'b1;
            end
            if (gnt_dm) begin
                state_d = WAIT_DM;
            end else if (gnt_if) begin
                state_d = WAIT_IF;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign owner = gnt_dm ? OWN_DM : OWN_IF;

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        if (gnt_dm || gnt_if) begin
            case (owner)
                OWN_DM: begin
                    sel_addr = bus.dm_addr;
                    sel_we   = bus.dm_we;
                    // Reads present zero strobes/data so the memory never sees stale write payload.
                    if (bus.dm_we) begin
                        sel_be    = bus.dm_be;
                        sel_wdata = bus.dm_wdata;
                    end
                end
                OWN_IF: begin
                    sel_addr = bus.if_addr;
                end
                default: begin
                    sel_addr = '0;
                end
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (bus.if_req),
        .if_gnt   (gnt_if),
        .dm_gnt   (gnt_dm),
        .force_if (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    assign bus.if_gnt    = gnt_if;
    assign bus.dm_gnt    = gnt_dm;
    assign bus.mem_req   = gnt_if || gnt_dm;
    assign bus.mem_we    = sel_we;
    assign bus.mem_be    = sel_be;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    // A response seen in IDLE has no owner and is dropped here.
    assign bus.if_rvalid = bus.mem_rvalid && (state_q == WAIT_IF);
    assign bus.dm_rvalid = bus.mem_rvalid && (state_q == WAIT_DM);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;

    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then randomized traffic with a memory model.
// Expected responses are queued at grant time and popped by the monitor on rvalid.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_w(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        chk_w(nm, 160'(act), 160'(exp));
    endtask

    // Two views of memory: what the DUT actually wrote, and what the requesters asked to write.
    logic [31:0] env_mem [int];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] env_rd(input int w);
        return env_mem.exists(w) ? env_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    typedef struct {
        bit          own_dm;
        bit          has_data;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   streak = 0;

    int          mem_cnt = 0;
    logic [31:0] mem_dat = '0;
    int          cur_lat = 1;
    bit          lat_rand = 1'b0;
    bit          inject_spurious = 1'b0;
    bit          rand_en = 1'b0;
    bit          if_taken = 1'b0;
    bit          dm_taken = 1'b0;

    // Memory response driver and random requesters, updated just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            mem_cnt        = 0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
        end else if (inject_spurious) begin
            inject_spurious = 1'b0;
            bus.mem_rvalid  = 1'b1;
            bus.mem_rdata   = 32'hBAD0_0BAD;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            bus.mem_rvalid = (mem_cnt == 0);
            bus.mem_rdata  = (mem_cnt == 0) ? mem_dat : '0;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
        end
        if (rand_en) begin
            if (!bus.if_req || if_taken) begin
                if_taken    = 1'b0;
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = rand_addr();
            end
            if (!bus.dm_req || dm_taken) begin
                dm_taken     = 1'b0;
                bus.dm_req   = ($urandom_range(0, 2) != 0);
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_be    = 4'($urandom_range(0, 15));
                bus.dm_addr  = rand_addr();
                bus.dm_wdata = $urandom;
            end
        end
    end

    // Monitor: rule-level reference of the arbiter plus response scoreboard.
    always @(negedge clk) begin : monitor
        bit   rsp, free_c, force_c, exp_dm, exp_if;
        exp_t e;
        int   w;
        if (!reset_n) begin
            sbq.delete();
            streak   = 0;
            if_taken = 1'b0;
            dm_taken = 1'b0;
            chk_w("reset_outputs",
                  160'({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.dm_gnt, bus.dm_rvalid,
                        bus.dm_rdata, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr,
                        bus.mem_wdata, bus.busy}), 160'(0));
        end else begin
            rsp = bus.mem_rvalid && (sbq.size() > 0);
            chk_b("busy", bus.busy, sbq.size() > 0);
            chk_b("if_rvalid", bus.if_rvalid, rsp ? !sbq[0].own_dm : 1'b0);
            chk_b("dm_rvalid", bus.dm_rvalid, rsp ? sbq[0].own_dm : 1'b0);
            if (rsp) begin
                e = sbq.pop_front();
                if (e.has_data)
                    chk_w(e.own_dm ? "dm_rdata" : "if_rdata",
                          160'(e.own_dm ? bus.dm_rdata : bus.if_rdata), 160'(e.data));
            end
            free_c  = (sbq.size() == 0);
            force_c = GUARD && (streak >= SMAX) && bus.if_req;
            exp_dm  = free_c && bus.dm_req && !force_c;
            exp_if  = free_c && bus.if_req && !exp_dm;
            chk_b("dm_gnt", bus.dm_gnt, exp_dm);
            chk_b("if_gnt", bus.if_gnt, exp_if);
            chk_b("mem_req", bus.mem_req, exp_dm || exp_if);
            if (exp_dm) begin
                chk_w("mem_addr_dm", 160'(bus.mem_addr), 160'(bus.dm_addr));
                chk_b("mem_we_dm", bus.mem_we, bus.dm_we);
                chk_w("mem_be_dm", 160'(bus.mem_be), 160'(bus.dm_we ? bus.dm_be : 4'b0));
                chk_w("mem_wdata_dm", 160'(bus.mem_wdata), 160'(bus.dm_we ? bus.dm_wdata : 32'b0));
                w = int'(bus.dm_addr >> 2);
                sbq.push_back('{own_dm: 1'b1, has_data: !bus.dm_we, data: ref_rd(w)});
                if (bus.dm_we) ref_mem[w] = merge(ref_rd(w), bus.dm_wdata, bus.dm_be);
                dm_taken = 1'b1;
            end else if (exp_if) begin
                chk_w("mem_addr_if", 160'(bus.mem_addr), 160'(bus.if_addr));
                chk_w("mem_wr_fields_if", 160'({bus.mem_we, bus.mem_be, bus.mem_wdata}), 160'(0));
                w = int'(bus.if_addr >> 2);
                sbq.push_back('{own_dm: 1'b0, has_data: 1'b1, data: ref_rd(w)});
                if_taken = 1'b1;
            end
            if (exp_if || !bus.if_req) streak = 0;
            else if (exp_dm && streak < SMAX) streak++;
            // The memory honours whatever the DUT presents.
            if (bus.mem_req) begin
                w       = int'(bus.mem_addr >> 2);
                mem_dat = env_rd(w);
                if (bus.mem_we) env_mem[w] = merge(env_rd(w), bus.mem_wdata, bus.mem_be);
                mem_cnt = lat_rand ? int'($urandom_range(1, 3)) : cur_lat;
            end
        end
    end

    task automatic at_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk_b("drain_done", sbq.size() == 0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic dm_set(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_be    = be;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
    endtask

    initial begin : directed
        logic [9:0] pat, pat_exp;
        int cnt;
        bus.if_req = 1'b1;  bus.if_addr = '0;
        bus.dm_req = 1'b0;  bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // Reset held three cycles with a fetch request pending.
        repeat (3) @(negedge clk);
        at_drive();
        reset_n = 1'b1;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk_w("idle_outputs",
              160'({bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.mem_req,
                    bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.busy}), 160'(0));
        repeat (2) @(negedge clk);

        // Fetch stream at L=1.
        cur_lat = 1;
        at_drive();
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_b("fetch_gnt", bus.if_gnt, 1'b1);
            chk_b("fetch_mem_req", bus.mem_req, 1'b1);
            if (i > 0) chk_b("fetch_rvalid", bus.if_rvalid, 1'b1);
            at_drive();
            bus.if_addr = bus.if_addr + 32'd4;
        end
        bus.if_req = 1'b0;
        drain();

        // Contention: data wins, fetch granted in the response cycle.
        at_drive();
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        dm_set(1'b0, 4'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk_b("cont_dm_gnt", bus.dm_gnt, 1'b1);
        chk_b("cont_if_gnt", bus.if_gnt, 1'b0);
        at_drive();
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk_b("cont_dm_rvalid", bus.dm_rvalid, 1'b1);
        chk_b("cont_if_gnt_late", bus.if_gnt, 1'b1);
        at_drive();
        bus.if_req = 1'b0;
        drain();

        // Both requesters held: grant pattern depends on the guard.
        at_drive();
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        dm_set(1'b0, 4'b0, 32'h300, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i]     = bus.if_gnt;
            pat_exp[i] = GUARD && ((i % (SMAX + 1)) == SMAX);
        end
        chk_w("starve_pattern", 160'(pat), 160'(pat_exp));
        at_drive();
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        drain();

        // Partial write at L=3 while fetch waits.
        cur_lat = 3;
        at_drive();
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        dm_set(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
        @(negedge clk);
        chk_b("wr_dm_gnt", bus.dm_gnt, 1'b1);
        chk_w("wr_mem_be", 160'(bus.mem_be), 160'(4'b0011));
        at_drive();
        bus.dm_req = 1'b0;
        cnt = 0;
        while (cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (bus.dm_rvalid) break;
            chk_b("wr_if_blocked", bus.if_gnt, 1'b0);
            chk_b("wr_busy", bus.busy, 1'b1);
        end
        chk_w("wr_latency", 160'(cnt), 160'(3));
        chk_b("wr_if_gnt_at_rsp", bus.if_gnt, 1'b1);
        at_drive();
        bus.if_req = 1'b0;
        drain();
        cur_lat = 1;
        at_drive();
        dm_set(1'b0, 4'b0, 32'h200, 32'h0);
        @(negedge clk);
        at_drive();
        bus.dm_req = 1'b0;
        drain();

        // Reset while a data read is outstanding, then a late spurious response.
        cur_lat = 3;
        at_drive();
        dm_set(1'b0, 4'b0, 32'h204, 32'h0);
        @(negedge clk);
        at_drive();
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk_b("pre_reset_busy", bus.busy, 1'b1);
        at_drive();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        at_drive();
        reset_n = 1'b1;
        inject_spurious = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_b("spur_seen", bus.mem_rvalid, 1'b1);
        chk_b("spur_if_rvalid", bus.if_rvalid, 1'b0);
        chk_b("spur_dm_rvalid", bus.dm_rvalid, 1'b0);
        chk_b("spur_busy", bus.busy, 1'b0);
        at_drive();
        bus.if_req = 1'b1; bus.if_addr = 32'h4C;
        @(negedge clk);
        chk_b("post_reset_if_gnt", bus.if_gnt, 1'b1);
        at_drive();
        bus.if_req = 1'b0;
        drain();

        // Randomized traffic with random latency 1..3.
        lat_rand = 1'b1;
        rand_en  = 1'b1;
        repeat (3000) @(negedge clk);
        rand_en = 1'b0;
        at_drive();
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
